// File: rtl/game_timer.sv
// game_timer
// Countdown timer for a single game round. Watches the game FSM's
// game_active level. A rising edge of that level reloads the count from
// GAME_SECONDS and starts a one-second countdown. Reaching zero produces a
// one-cycle timer_expired pulse for the game FSM.
//
// Ports:
//   clkIn         in   system clock (CLK_HZ cycles per second)
//   reset         in   asynchronous, active-high reset
//   game_active   in   registered level from the game FSM, high during a round
//   seconds_left  out  remaining seconds, binary
//   secs_tens     out  BCD tens digit of seconds_left
//   secs_ones     out  BCD ones digit of seconds_left
//   sec_tick      out  one-cycle pulse on every seconds decrement
//   timer_expired out  one-cycle pulse when the count reaches 0
//   low_time      out  high while counting with seconds_left <= WARN_SECONDS
//
// The FSM state is visible on the internal signal 'state' (type state_t).
module game_timer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 30,
    parameter int WARN_SECONDS = 5
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic       game_active,
    output logic [6:0] seconds_left,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       sec_tick,
    output logic       timer_expired,
    output logic       low_time
);

    // Keep the prescaler at least one bit wide so CLK_HZ=1 still elaborates.
    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0]    LOAD_SECS  = 7'(GAME_SECONDS);
    localparam logic [3:0]    LOAD_TENS  = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    LOAD_ONES  = 4'(GAME_SECONDS % 10);
    localparam logic [6:0]    WARN_LIM   = 7'(WARN_SECONDS);
    // A round that starts already inside the warning window raises low_time at once.
    localparam logic          LOAD_LOW   = (GAME_SECONDS <= WARN_SECONDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_EXPIRED  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          active_d;
    logic [6:0]    secs_n;
    logic [3:0]    tens_n, ones_n;
    logic          tick_n, expired_n, low_n;
    logic          start;
    logic          terminal;

    assign start    = game_active & ~active_d;
    assign terminal = (presc == PRESC_LAST);

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            presc         <= '0;
            active_d      <= 1'b0;
            seconds_left  <= LOAD_SECS;
            secs_tens     <= LOAD_TENS;
            secs_ones     <= LOAD_ONES;
            sec_tick      <= 1'b0;
            timer_expired <= 1'b0;
            low_time      <= 1'b0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            active_d      <= game_active;
            seconds_left  <= secs_n;
            secs_tens     <= tens_n;
            secs_ones     <= ones_n;
            sec_tick      <= tick_n;
            timer_expired <= expired_n;
            low_time      <= low_n;
        end
    end

    always_comb begin
        state_n   = state;
        presc_n   = presc;
        secs_n    = seconds_left;
        tens_n    = secs_tens;
        ones_n    = secs_ones;
        tick_n    = 1'b0;
        expired_n = 1'b0;
        low_n     = low_time;

        if (start) begin
            // A new round restarts from any state, including mid-count.
            state_n = ST_COUNTING;
            presc_n = '0;
            secs_n  = LOAD_SECS;
            tens_n  = LOAD_TENS;
            ones_n  = LOAD_ONES;
            low_n   = LOAD_LOW;
        end else begin
            case (state)
                ST_COUNTING: begin
                    if (!game_active) begin
                        // Abort wins over a coinciding terminal prescaler count.
                        state_n = ST_IDLE;
                        low_n   = 1'b0;
                    end else if (terminal) begin
                        presc_n = '0;
                        tick_n  = 1'b1;
                        secs_n  = seconds_left - 7'd1;
                        if (secs_ones == 4'd0) begin
                            ones_n = 4'd9;
                            tens_n = secs_tens - 4'd1;
                        end else begin
                            ones_n = secs_ones - 4'd1;
                        end
                        // COUNTING is only entered with a nonzero count, so
                        // the decrement from 1 is always the last one.
                        if (seconds_left == 7'd1) begin
                            expired_n = 1'b1;
                            state_n   = ST_EXPIRED;
                            low_n     = 1'b0;
                        end else begin
                            low_n = (secs_n <= WARN_LIM);
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                ST_EXPIRED: begin
                    // Count is held at 0 until the FSM drops game_active.
                    if (!game_active) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    // IDLE: count frozen until the next start event.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer. Two instances share clock, reset and game_active:
// dut_a runs a 3-second round and dut_b a 12-second round (to exercise the
// BCD borrow), both with CLK_HZ=10 and WARN_SECONDS=1. A reference model
// tracks elapsed cycles since each start and derives the expected count,
// digits and pulses arithmetically.
module tb_game_timer;

    localparam int HZ   = 10;
    localparam int WARN = 1;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic       clk;
    logic       rst;
    logic       ga;

    logic [6:0] sl_a, sl_b;
    logic [3:0] tens_a, tens_b, ones_a, ones_b;
    logic       tick_a, tick_b, exp_a, exp_b, low_a, low_b;

    int checks;
    int errors;

    // reference model state, index 0 = dut_a, 1 = dut_b
    int gs_tab[2];
    int m_phase[2];
    int m_elapsed[2];
    int m_secs[2];
    bit m_prev[2];
    bit m_tick[2];
    bit m_exp[2];

    int tick_cnt_a;
    int exp_cnt_a;

    game_timer #(.CLK_HZ(HZ), .GAME_SECONDS(3), .WARN_SECONDS(WARN)) dut_a (
        .clkIn(clk), .reset(rst), .game_active(ga),
        .seconds_left(sl_a), .secs_tens(tens_a), .secs_ones(ones_a),
        .sec_tick(tick_a), .timer_expired(exp_a), .low_time(low_a)
    );

    game_timer #(.CLK_HZ(HZ), .GAME_SECONDS(12), .WARN_SECONDS(WARN)) dut_b (
        .clkIn(clk), .reset(rst), .game_active(ga),
        .seconds_left(sl_b), .secs_tens(tens_b), .secs_ones(ones_b),
        .sec_tick(tick_b), .timer_expired(exp_b), .low_time(low_b)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i]   = PH_IDLE;
            m_elapsed[i] = 0;
            m_secs[i]    = gs_tab[i];
            m_prev[i]    = 1'b0;
            m_tick[i]    = 1'b0;
            m_exp[i]     = 1'b0;
        end
    endtask

    // Advance the model by one clock edge with the sampled game_active.
    task automatic model_edge(input bit g);
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 1'b0;
            m_exp[i]  = 1'b0;
            if (g && !m_prev[i]) begin
                m_phase[i]   = PH_RUN;
                m_elapsed[i] = 0;
                m_secs[i]    = gs_tab[i];
            end else if (m_phase[i] == PH_RUN) begin
                if (!g) begin
                    m_phase[i] = PH_IDLE;
                end else begin
                    m_elapsed[i]++;
                    if (m_elapsed[i] % HZ == 0) begin
                        m_tick[i] = 1'b1;
                        m_secs[i] = gs_tab[i] - m_elapsed[i] / HZ;
                        if (m_secs[i] == 0) begin
                            m_exp[i]   = 1'b1;
                            m_phase[i] = PH_DONE;
                        end
                    end
                end
            end else if (m_phase[i] == PH_DONE && !g) begin
                m_phase[i] = PH_IDLE;
            end
            m_prev[i] = g;
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
            $error("check %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        int lo0, lo1;
        lo0 = (m_phase[0] == PH_RUN && m_secs[0] <= WARN) ? 1 : 0;
        lo1 = (m_phase[1] == PH_RUN && m_secs[1] <= WARN) ? 1 : 0;
        check("a_secs",  32'(sl_a),   m_secs[0]);
        check("a_tens",  32'(tens_a), m_secs[0] / 10);
        check("a_ones",  32'(ones_a), m_secs[0] % 10);
        check("a_tick",  32'(tick_a), 32'(m_tick[0]));
        check("a_exp",   32'(exp_a),  32'(m_exp[0]));
        check("a_low",   32'(low_a),  lo0);
        check("b_secs",  32'(sl_b),   m_secs[1]);
        check("b_tens",  32'(tens_b), m_secs[1] / 10);
        check("b_ones",  32'(ones_b), m_secs[1] % 10);
        check("b_tick",  32'(tick_b), 32'(m_tick[1]));
        check("b_exp",   32'(exp_b),  32'(m_exp[1]));
        check("b_low",   32'(low_b),  lo1);
        if (tick_a === 1'b1) tick_cnt_a++;
        if (exp_a === 1'b1) exp_cnt_a++;
    endtask

    // ----------------------------------------------------------------- driver
    // Drive inputs away from the edge, clock once, sample on the falling edge.
    task automatic step(input bit g, input bit r);
        ga  = g;
        rst = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(g);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input bit g, input int n);
        for (int k = 0; k < n; k++) step(g, 1'b0);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int seg_len;
        bit seg_ga;

        checks     = 0;
        errors     = 0;
        tick_cnt_a = 0;
        exp_cnt_a  = 0;
        gs_tab[0]  = 3;
        gs_tab[1]  = 12;
        rst        = 1'b1;
        ga         = 1'b0;
        model_reset();

        // Reset values, then a long idle stretch with nothing changing.
        repeat (3) step(1'b0, 1'b1);
        run(1'b0, 50);

        // Full round: ticks after E+10/20/30, one expiry pulse, 5 cycles held.
        tick_cnt_a = 0;
        exp_cnt_a  = 0;
        run(1'b1, 36);
        check("a_round_ticks", 32'(tick_cnt_a), 3);
        check("a_round_expiries", 32'(exp_cnt_a), 1);

        // Drop, wait, raise again: reloads to 3 and counts again.
        run(1'b0, 10);
        check("a_held_zero", 32'(sl_a), 0);
        exp_cnt_a = 0;
        run(1'b1, 40);
        check("a_second_round_expiries", 32'(exp_cnt_a), 1);
        run(1'b0, 5);

        // Abort after E+15: count frozen at 2, no pulses for 100 cycles.
        run(1'b1, 16);
        tick_cnt_a = 0;
        exp_cnt_a  = 0;
        run(1'b0, 100);
        check("a_abort_frozen", 32'(sl_a), 2);
        check("a_abort_no_tick", 32'(tick_cnt_a), 0);
        check("a_abort_no_exp", 32'(exp_cnt_a), 0);

        // Abort on the terminal prescaler edge E+20: abort wins.
        run(1'b1, 20);
        step(1'b0, 1'b0);
        check("a_terminal_abort_secs", 32'(sl_a), 2);
        check("a_terminal_abort_tick", 32'(tick_a), 0);
        run(1'b0, 10);

        // 12-second round: after three decrements the BCD borrow shows 0/9.
        run(1'b1, 31);
        check("b_borrow_secs", 32'(sl_b), 9);
        check("b_borrow_tens", 32'(tens_b), 0);
        check("b_borrow_ones", 32'(ones_b), 9);
        run(1'b1, 4);

        // Asynchronous reset mid-count, checked before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        run(1'b0, 3);

        // Randomized segments of game_active levels with occasional resets.
        for (int s = 0; s < 24; s++) begin
            seg_ga  = 1'($urandom_range(0, 1));
            seg_len = $urandom_range(1, 45);
            if ($urandom_range(0, 9) == 0) step(seg_ga, 1'b1);
            run(seg_ga, seg_len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
